// File: rtl/matrix_addr_gen.sv
// Linear address generator for the MACC 2D row/column counter: addr = base + row*stride + col,
// emitted through a 2-stage valid/ready pipeline. Optional MATRIX_ADDR_GEN_TRANSPOSE_EN adds a column-major formula.
module matrix_addr_gen #(
    parameter int ADDR_W = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VDD,
    input  logic              GND,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [10:0]       stride,
    input  logic [9:0]        row_max,
    input  logic [9:0]        col_max,
    input  logic [9:0]        row,
    input  logic [9:0]        col,
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
    input  logic              transpose,
`endif
    output logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              done
);

    localparam int PROD_W = 21;
    localparam int SUM_W  = ((ADDR_W > PROD_W) ? ADDR_W : PROD_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [10:0]         stride_reg;
    logic                v1_reg;
    logic [9:0]          col1_reg;
    logic [PROD_W-1:0]   prod1_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                addr_valid_reg;
    logic                done_reg;
    logic                done_next;
    logic                adv;
    logic [9:0]          mul_src;
    logic [9:0]          add_src;
    logic                unused_power;

    // Power pins carry no logic; they are only gathered here.
    assign unused_power = VDD ^ GND;

`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
    logic transpose_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            transpose_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            transpose_reg <= transpose;
        end
    end

    assign mul_src = transpose_reg ? col : row;
    assign add_src = transpose_reg ? row : col;
`else
    assign mul_src = row;
    assign add_src = col;
`endif

    // Whole pipeline moves together whenever the output slot is free or being taken.
    assign adv = !addr_valid_reg || addr_ready;

    always_comb begin
        state_next = state_reg;
        inc        = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (adv) begin
                    inc = 1'b1;
                    if (row == row_max && col == col_max) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // S1 empty and S2 handing off its last word: pipeline is empty after this edge.
                if (adv && !v1_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            stride_reg     <= '0;
            v1_reg         <= 1'b0;
            col1_reg       <= '0;
            prod1_reg      <= '0;
            addr_reg       <= '0;
            addr_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (state_reg == IDLE && start) begin
                base_reg   <= base;
                stride_reg <= stride;
            end
            if (adv) begin
                v1_reg         <= inc;
                col1_reg       <= add_src;
                prod1_reg      <= PROD_W'(mul_src) * PROD_W'(stride_reg);
                addr_valid_reg <= v1_reg;
                addr_reg       <= ADDR_W'(SUM_W'(base_reg) + SUM_W'(prod1_reg) + SUM_W'(col1_reg));
            end
        end
    end

    assign addr       = addr_reg;
    assign addr_valid = addr_valid_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_matrix_addr_gen.sv
// Self-checking bench for matrix_addr_gen: drives a behavioural row/col counter and compares the
// accepted address stream against a nested-loop reference of base + row*stride + col.
module tb_matrix_addr_gen;

    localparam int ADDR_W = 20;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              VDD = 1'b1;
    logic              GND = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [10:0]       stride = '0;
    logic [9:0]        row_max = '0;
    logic [9:0]        col_max = '0;
    logic [9:0]        row;
    logic [9:0]        col;
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
    logic              transpose = 1'b0;
`endif
    logic              inc;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready = 1'b0;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] got_q[$];
    logic [ADDR_W-1:0] exp_q[$];
    int  n_inc, n_done, first_busy, first_inc, first_valid, first_hs, last_hs, done_cyc;
    int  hold_changes, stall_inc;
    bit  timeout, done_after, busy_after, busy_at_done;
    logic [9:0] end_row, end_col;

    matrix_addr_gen #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .VDD        (VDD),
        .GND        (GND),
        .start      (start),
        .base       (base),
        .stride     (stride),
        .row_max    (row_max),
        .col_max    (col_max),
        .row        (row),
        .col        (col),
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .inc        (inc),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Upstream 2D counter, reset from the same source as the DUT.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == col_max) begin
                col <= '0;
                row <= (row == row_max) ? 10'd0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    function automatic void build_expected(input logic [ADDR_W-1:0] b, input logic [10:0] s,
                                           input int rm, input int cm, input bit tr);
        longint a;
        exp_q.delete();
        for (int r = 0; r <= rm; r++) begin
            for (int c = 0; c <= cm; c++) begin
                a = longint'(b) + (tr ? (longint'(c) * longint'(s) + r) : (longint'(r) * longint'(s) + c));
                exp_q.push_back(ADDR_W'(a));
            end
        end
    endfunction

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1,0,0 repeating.
    // abort_at > 0 returns right after that many accepted addresses, mid-pass.
    task automatic run_pass(input logic [ADDR_W-1:0] b, input logic [10:0] s, input logic [9:0] rm,
                            input logic [9:0] cm, input int mode, input int abort_at);
        int budget = 4 * (int'(rm) + 1) * (int'(cm) + 1) + 20;
        bit finished = 1'b0;
        bit prev_stall = 1'b0;
        logic [ADDR_W-1:0] prev_addr = '0;
        got_q.delete();
        n_inc = 0; n_done = 0; hold_changes = 0; stall_inc = 0;
        first_busy = -1; first_inc = -1; first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
        busy_at_done = 1'b1;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                base = b; stride = s; row_max = rm; col_max = cm;
            end
            start = (c == 0);
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = 1'($urandom_range(0, 1));
                default: addr_ready = (c % 3 == 0);
            endcase
            #1;
            if (prev_stall && (addr !== prev_addr || addr_valid !== 1'b1)) hold_changes++;
            if (busy && first_busy < 0) first_busy = c;
            if (inc) begin
                n_inc++;
                if (first_inc < 0) first_inc = c;
            end
            if (addr_valid && first_valid < 0) first_valid = c;
            if (addr_valid && !addr_ready && inc) stall_inc++;
            if (done) begin
                n_done++;
                done_cyc = c;
                busy_at_done = busy;
                finished = 1'b1;
            end
            if (addr_valid && addr_ready) begin
                got_q.push_back(addr);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                if (abort_at > 0 && got_q.size() == abort_at) finished = 1'b1;
            end
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = addr;
        end
        timeout = !finished;
        if (abort_at == 0) begin
            @(negedge CLK);
            start = 1'b0;
            #1;
            done_after = done;
            busy_after = busy;
            end_row    = row;
            end_col    = col;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        total++; if (addr !== '0)      begin bad++; $display("FAIL reset_addr: got %0h expected 0", addr); end
        total++; if (addr_valid !== 0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", addr_valid); end
        total++; if (busy !== 0)       begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (done !== 0)       begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
        total++; if (inc !== 0)        begin bad++; $display("FAIL reset_inc: got %0b expected 0", inc); end
        @(negedge CLK);
        RST = 1'b0;
        run_pass(20'h02000, 11'd16, 10'd3, 10'd3, 0, 5);
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL midrun_count: got %0d expected 5", got_q.size()); end
        RST = 1'b1;
        #1;
        total++; if (addr !== '0)      begin bad++; $display("FAIL midrst_addr: got %0h expected 0", addr); end
        total++; if (addr_valid !== 0) begin bad++; $display("FAIL midrst_valid: got %0b expected 0", addr_valid); end
        total++; if (busy !== 0)       begin bad++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        total++; if (inc !== 0)        begin bad++; $display("FAIL midrst_inc: got %0b expected 0", inc); end
        @(negedge CLK);
        RST = 1'b0;
        build_expected(20'h02000, 11'd16, 3, 3, 1'b0);
        run_pass(20'h02000, 11'd16, 10'd3, 10'd3, 0, 0);
        total++; if (timeout) begin bad++; $display("FAIL rerun_timeout: got timeout expected done"); end
        total++; if (got_q.size() != 16) begin bad++; $display("FAIL rerun_count: got %0d expected 16", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rerun_addr[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        $display("reset test: 5 addresses then reset, rerun produced %0d addresses", got_q.size());
    endtask

    task automatic test_basic();
        build_expected(20'h00100, 11'd8, 1, 2, 1'b0);
        run_pass(20'h00100, 11'd8, 10'd1, 10'd2, 0, 0);
        total++; if (timeout) begin bad++; $display("FAIL basic_timeout: got timeout expected done"); end
        total++; if (first_busy != 1)  begin bad++; $display("FAIL basic_busy_lat: got %0d expected 1", first_busy); end
        total++; if (first_inc != 1)   begin bad++; $display("FAIL basic_inc_lat: got %0d expected 1", first_inc); end
        total++; if (first_valid != 3) begin bad++; $display("FAIL basic_valid_lat: got %0d expected 3", first_valid); end
        total++; if (got_q.size() != 6) begin bad++; $display("FAIL basic_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_addr[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        total++; if (last_hs - first_hs != 5) begin bad++; $display("FAIL basic_throughput: got span %0d expected 5", last_hs - first_hs); end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, last_hs + 1); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %0b expected 0", busy_at_done); end
        total++; if (n_inc != 6) begin bad++; $display("FAIL basic_inc_count: got %0d expected 6", n_inc); end
        total++; if (done_after !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %0b expected 0", done_after); end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %0b expected 0", busy_after); end
        $display("basic test: %0d addresses, done at cycle %0d", got_q.size(), done_cyc);
    endtask

    task automatic test_backpressure();
        build_expected(20'h00100, 11'd8, 1, 2, 1'b0);
        run_pass(20'h00100, 11'd8, 10'd1, 10'd2, 2, 0);
        total++; if (timeout) begin bad++; $display("FAIL bp_timeout: got timeout expected done"); end
        total++; if (got_q.size() != 6) begin bad++; $display("FAIL bp_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_addr[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        total++; if (hold_changes != 0) begin bad++; $display("FAIL bp_hold: got %0d changes expected 0", hold_changes); end
        total++; if (stall_inc != 0)    begin bad++; $display("FAIL bp_stall_inc: got %0d expected 0", stall_inc); end
        total++; if (n_inc != 6)        begin bad++; $display("FAIL bp_inc_count: got %0d expected 6", n_inc); end
        total++; if (end_row !== 0 || end_col !== 0) begin bad++; $display("FAIL bp_counter_end: got (%0d,%0d) expected (0,0)", end_row, end_col); end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL bp_done_time: got %0d expected %0d", done_cyc, last_hs + 1); end
        $display("backpressure test: %0d addresses, done at cycle %0d", got_q.size(), done_cyc);
    endtask

    task automatic test_one_by_one();
        run_pass(20'hFFFFF, 11'd5, 10'd0, 10'd0, 0, 0);
        total++; if (timeout) begin bad++; $display("FAIL one_timeout: got timeout expected done"); end
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL one_count: got %0d expected 1", got_q.size()); end
        total++; if (got_q[0] !== 20'hFFFFF) begin bad++; $display("FAIL one_addr: got %0h expected fffff", got_q[0]); end
        total++; if (n_inc != 1)  begin bad++; $display("FAIL one_inc_count: got %0d expected 1", n_inc); end
        total++; if (n_done != 1) begin bad++; $display("FAIL one_done_count: got %0d expected 1", n_done); end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL one_done_time: got %0d expected %0d", done_cyc, last_hs + 1); end
        $display("1x1 test: addr %0h, inc count %0d", got_q[0], n_inc);
    endtask

    task automatic test_wrap();
        build_expected(20'hFFFF0, 11'h020, 1, 0, 1'b0);
        run_pass(20'hFFFF0, 11'h020, 10'd1, 10'd0, 0, 0);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL wrap_count: got %0d expected 2", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
        $display("wrap test: %0h then %0h", got_q[0], got_q[1]);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] b;
        logic [10:0] s;
        logic [9:0] rm, cm;
        bit tr;
        for (int p = 0; p < 10; p++) begin
            b  = ADDR_W'($urandom);
            s  = 11'($urandom_range(0, 2047));
            rm = 10'($urandom_range(0, 4));
            cm = 10'($urandom_range(0, 4));
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
            tr = 1'($urandom_range(0, 1));
            transpose = tr;
`else
            tr = 1'b0;
`endif
            build_expected(b, s, int'(rm), int'(cm), tr);
            run_pass(b, s, rm, cm, 1, 0);
            total++; if (timeout) begin bad++; $display("FAIL rnd%0d_timeout: got timeout expected done", p); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d expected %0d", p, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_addr[%0d]: got %0h expected %0h", p, i, got_q[i], exp_q[i]); end
            end
            total++; if (hold_changes != 0) begin bad++; $display("FAIL rnd%0d_hold: got %0d expected 0", p, hold_changes); end
            total++; if (n_inc != exp_q.size()) begin bad++; $display("FAIL rnd%0d_inc_count: got %0d expected %0d", p, n_inc, exp_q.size()); end
            total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL rnd%0d_done_time: got %0d expected %0d", p, done_cyc, last_hs + 1); end
            total++; if (end_row !== 0 || end_col !== 0) begin bad++; $display("FAIL rnd%0d_counter_end: got (%0d,%0d) expected (0,0)", p, end_row, end_col); end
            $display("random pass %0d: base %0h stride %0d size %0dx%0d tr %0b -> %0d addresses", p, b, s, rm + 1, cm + 1, tr, got_q.size());
        end
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
        transpose = 1'b0;
`endif
    endtask

`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
    task automatic test_transpose();
        logic [ADDR_W-1:0] want[4];
        want[0] = 20'd0; want[1] = 20'd4; want[2] = 20'd1; want[3] = 20'd5;
        transpose = 1'b1;
        run_pass(20'h00000, 11'd4, 10'd1, 10'd1, 0, 0);
        transpose = 1'b0;
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL tr_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q[i] !== want[i]) begin bad++; $display("FAIL tr_addr[%0d]: got %0h expected %0h", i, got_q[i], want[i]); end
        end
        $display("transpose test: %0d addresses", got_q.size());
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_one_by_one();
        test_wrap();
        test_random();
`ifdef MATRIX_ADDR_GEN_TRANSPOSE_EN
        test_transpose();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_addr_gen.md
# matrix_addr_gen

Address generator directly downstream of the 2D row/column counter in the MACC datapath. It drives the counter's `inc` and turns each (row, col) pair into a linear memory address, `addr = base + row*stride + col`. Addresses leave through a 2-stage pipeline with a valid/ready handshake toward the operand-fetch memory port. One `start` produces exactly `(row_max+1)*(col_max+1)` addresses in row-major order, then a `done` pulse.

## Interface
- `ADDR_W`, default 20: output address width; wider results are truncated to ADDR_W LSBs.
- `CLK` input 1: clock; all flops on posedge.
- `RST` input 1: asynchronous, active-high reset.
- `VDD`, `GND` input 1 each: power pins; no logic attached.
- `start` input 1: begin a pass; sampled only in IDLE.
- `base` input ADDR_W: matrix base address; captured on accepted `start`.
- `stride` input 11: row pitch in words; captured on accepted `start`.
- `row_max`, `col_max` input 10 each: last row and last column indices. The same values feed the counter. Held stable while `busy`.
- `row`, `col` input 10 each: current counter outputs.
- `inc` output 1: advance the counter; asserted in the cycle a coordinate is consumed.
- `addr` output ADDR_W: generated address.
- `addr_valid` output 1: `addr` is valid.
- `addr_ready` input 1: consumer accepts `addr` this cycle.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: single-cycle pulse when the last address has been accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: `start`=1 captures `base`/`stride` and moves to RUN.
- RUN: consumes one coordinate per `adv` cycle. If the consumed coordinate has `row==row_max && col==col_max`, move to DRAIN.
- DRAIN: no new coordinates. When both pipeline stages are empty, pulse `done` and return to IDLE.
- `adv = !addr_valid || addr_ready`. The whole pipeline advances only on `adv`.
- `inc = (state==RUN) && adv`. This is combinational from `addr_ready`.
- S1 (on `adv`):
  - loads `v1 <= inc`, `col1 <= col`, `prod1 <= row*stride` (21-bit).
- S2 (on `adv`):
  - `addr <= base + prod1 + col1`, truncated to ADDR_W;
  - `addr_valid <= v1`.
- Output hold: while `addr_valid && !addr_ready`, `addr` and `addr_valid` are unchanged and `inc`=0.
- Precondition: the counter sits at (0,0) at `start`. The counter's own wrap after the last increment guarantees this for every later pass.
- `start` while busy is ignored. `row_max`/`col_max` changes while busy are unsupported.
- Degenerate 1x1 case (`row_max=col_max=0`): one address, RUN lasts one `adv` cycle.
- Reset:
  - Returns state to IDLE and clears `v1`, `addr_valid`, `addr`, `busy`, `done`, `base`, `stride`.
  - Any in-flight address is dropped.
  - The counter reset is driven from the same source, so the counter also returns to (0,0).

## Timing
- Reset values: `addr`=0, `addr_valid`=0, `busy`=0, `done`=0, `inc`=0.
- `start` at cycle T:
  - `busy` and first `inc` at T+1;
  - first `addr_valid` at T+3.
- Throughput is 1 address/cycle with `addr_ready` held high. `inc` at cycle n yields the new counter value at n+1, so back-to-back consumption is exact.
- Pipeline latency from coordinate consumed to `addr_valid` is 2 cycles.
- `done` asserts the cycle after the last `addr` handshake completes; `busy` falls the same cycle. A new `start` is accepted in the following cycle (IDLE).
- Backpressure: each cycle with `addr_ready`=0 while valid adds exactly one cycle and drops no `inc`.

## Configuration
- `MATRIX_ADDR_GEN_TRANSPOSE_EN`:
  - Defined: adds input `transpose` (1 bit, captured with `start`). When it is 1, `prod1 = col*stride` and the row feeds the adder, giving `addr = base + col*stride + row`. Counter order is unchanged.
  - Undefined: no port is added and the row-major formula always applies.

## Test plan
- Reset mid-RUN (`row_max=col_max=3`, assert `RST` after 5 addresses): all outputs 0 at once, IDLE. A new `start` yields 16 addresses again from `base`.
- `row_max=1`, `col_max=2`, `stride=8`, `base=0x100`, `addr_ready`=1:
  - addresses 0x100, 0x101, 0x102, 0x108, 0x109, 0x10A on consecutive cycles;
  - `done` one cycle after 0x10A.
- Same config with `addr_ready` toggling 1,0,0,1,…: identical address sequence, each held stable while stalled, no skipped or duplicated `inc` (counter ends at (0,0)).
- 1x1 matrix, `base=0xFFFFF`, `stride=5`: single address 0xFFFFF, `done`, and `inc` asserted exactly once.
- Wrap check, `base=0xFFFF0`, `row_max=1`, `col_max=0`, `stride=0x20`: addresses 0xFFFF0, then 0x00010 (truncated to 20 bits).
- With `MATRIX_ADDR_GEN_TRANSPOSE_EN` and `transpose=1`, `row_max=1`, `col_max=1`, `stride=4`, `base=0`: addresses 0, 4, 1, 5.
